// File: rtl/adc_burst_sched_pkg.sv
// Shared state encoding, tag defaults and tag selection for the ADC burst scheduler.
package adc_burst_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_PPS = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  localparam int DATA_W = 64;
  localparam int TAG_W  = 7;

  localparam logic [TAG_W-1:0] TAG_START_DEF  = 7'h01;
  localparam logic [TAG_W-1:0] TAG_END_DEF    = 7'h02;
  localparam logic [TAG_W-1:0] TAG_SINGLE_DEF = 7'h03;

  // A beat that both opens and closes a burst carries the single tag.
  function automatic logic [TAG_W-1:0] sel_tag(
    input logic             first_beat,
    input logic             final_beat,
    input logic [TAG_W-1:0] tag_start,
    input logic [TAG_W-1:0] tag_end,
    input logic [TAG_W-1:0] tag_single
  );
    logic [TAG_W-1:0] tag;
    tag = '0;
    if (first_beat && final_beat) tag = tag_single;
    else if (first_beat)          tag = tag_start;
    else if (final_beat)          tag = tag_end;
    return tag;
  endfunction

endpackage

// File: rtl/adc_burst_out_reg.sv
// One-deep registered output stage carrying 64-bit data plus last/tag sideband.
// Handshake: a beat moves when valid and ready are both high on a rising clock edge;
// the output side holds every field stable while out_valid_o is high and out_ready_i low.
module adc_burst_out_reg
  import adc_burst_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  input  logic              in_tag_valid_i,
  input  logic [TAG_W-1:0]  in_tag_type_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              out_tag_valid_o,
  output logic [TAG_W-1:0]  out_tag_type_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic              tag_valid_q;
  logic [TAG_W-1:0]  tag_type_q;

  assign in_ready_o = !valid_q || out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_type_q  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q     <= 1'b1;
      data_q      <= in_data_i;
      last_q      <= in_last_i;
      tag_valid_q <= in_tag_valid_i;
      tag_type_q  <= in_tag_type_i;
    end else if (valid_q && out_ready_i) begin
      // Sideband is cleared on drain; data is left as-is.
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_type_q  <= '0;
    end
  end

  assign out_valid_o     = valid_q;
  assign out_data_o      = data_q;
  assign out_last_o      = last_q;
  assign out_tag_valid_o = tag_valid_q;
  assign out_tag_type_o  = tag_type_q;

endmodule

// File: rtl/adc_burst_scheduler.sv
// Gates an ADC sample stream into counted or continuous bursts, optionally PPS-aligned,
// with packet boundaries, start/end tags and a saturating count of discarded samples.
module adc_burst_scheduler
  import adc_burst_sched_pkg::*;
#(
  parameter int               CNT_W      = 32,
  parameter int               PKT_W      = 16,
  parameter logic [TAG_W-1:0] TAG_START  = TAG_START_DEF,
  parameter logic [TAG_W-1:0] TAG_END    = TAG_END_DEF,
  parameter logic [TAG_W-1:0] TAG_SINGLE = TAG_SINGLE_DEF
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic              pps,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_num,
  input  logic              cmd_at_pps,
  input  logic [PKT_W-1:0]  cmd_pkt_len,
  input  logic              cmd_stop,
  input  logic              s_adc_valid,
  output logic              s_adc_ready,
  input  logic [DATA_W-1:0] s_adc_data,
  output logic              m_adc_valid,
  input  logic              m_adc_ready,
  output logic [DATA_W-1:0] m_adc_data,
  output logic              m_adc_tag_valid,
  output logic [TAG_W-1:0]  m_adc_tag_type,
  output logic              m_adc_last,
  output logic              busy,
  output logic [31:0]       drop_cnt,
  output state_t            dbg_state
);

  state_t           state_q;
  logic             pps_q;
  logic [CNT_W-1:0] num_q;
  logic [PKT_W-1:0] pkt_len_q;
  logic [CNT_W-1:0] burst_cnt_q;
  logic [PKT_W-1:0] pkt_cnt_q;
  logic             stop_pend_q;
  logic [31:0]      drop_q;
  logic [31:0]      drop_d;

  logic in_run, or_in_ready, beat_acc, cmd_acc;
  logic first_beat, cnt_final, final_beat, pkt_last, pps_rise;

  assign in_run      = (state_q == ST_RUN);
  assign s_adc_ready = in_run ? or_in_ready : 1'b1;
  assign beat_acc    = in_run && s_adc_valid && or_in_ready;
  assign cmd_ready   = !user_rst && (state_q == ST_IDLE) && !m_adc_valid;
  assign cmd_acc     = cmd_valid && cmd_ready;
  assign pps_rise    = pps && !pps_q;

  assign first_beat = (burst_cnt_q == '0);
  // A zero sample count means continuous: the counter wraps and never ends the burst.
  assign cnt_final  = (num_q != '0) && (burst_cnt_q == num_q - CNT_W'(1));
  assign final_beat = cnt_final || stop_pend_q;
  assign pkt_last   = (pkt_len_q != '0) && (pkt_cnt_q == pkt_len_q - PKT_W'(1));

  always_comb begin
    drop_d = drop_q;
    if (!in_run && s_adc_valid && (drop_q != 32'hFFFF_FFFF)) drop_d = drop_q + 32'd1;
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q     <= ST_IDLE;
      pps_q       <= 1'b0;
      num_q       <= '0;
      pkt_len_q   <= '0;
      burst_cnt_q <= '0;
      pkt_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      pps_q  <= pps;
      drop_q <= drop_d;
      case (state_q)
        ST_IDLE: begin
          if (cmd_acc) begin
            num_q       <= cmd_num;
            pkt_len_q   <= cmd_pkt_len;
            burst_cnt_q <= '0;
            pkt_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            state_q     <= cmd_at_pps ? ST_WAIT_PPS : ST_RUN;
          end
        end
        ST_WAIT_PPS: begin
          if (cmd_stop)      state_q <= ST_IDLE;
          else if (pps_rise) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (beat_acc) begin
            burst_cnt_q <= burst_cnt_q + CNT_W'(1);
            pkt_cnt_q   <= pkt_last ? '0 : pkt_cnt_q + PKT_W'(1);
          end
          // A stop arriving with the final beat is absorbed so only one end is emitted.
          if (beat_acc && final_beat) begin
            state_q     <= ST_IDLE;
            stop_pend_q <= 1'b0;
          end else if (cmd_stop) begin
            stop_pend_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  adc_burst_out_reg u_out_reg (
    .clk             (user_clk),
    .rst             (user_rst),
    .in_valid_i      (beat_acc),
    .in_ready_o      (or_in_ready),
    .in_data_i       (s_adc_data),
    .in_last_i       (final_beat || pkt_last),
    .in_tag_valid_i  (first_beat || final_beat),
    .in_tag_type_i   (sel_tag(first_beat, final_beat, TAG_START, TAG_END, TAG_SINGLE)),
    .out_valid_o     (m_adc_valid),
    .out_ready_i     (m_adc_ready),
    .out_data_o      (m_adc_data),
    .out_last_o      (m_adc_last),
    .out_tag_valid_o (m_adc_tag_valid),
    .out_tag_type_o  (m_adc_tag_type)
  );

  assign busy      = (state_q != ST_IDLE) || m_adc_valid;
  assign drop_cnt  = drop_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adc_burst_scheduler.sv
// Directed-plus-random bench for adc_burst_scheduler against a burst-level reference model.
module tb_adc_burst_scheduler;
  import adc_burst_sched_pkg::*;

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic        pps;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_num;
  logic        cmd_at_pps;
  logic [15:0] cmd_pkt_len;
  logic        cmd_stop;
  logic        s_adc_valid;
  logic        s_adc_ready;
  logic [63:0] s_adc_data;
  logic        m_adc_valid;
  logic        m_adc_ready;
  logic [63:0] m_adc_data;
  logic        m_adc_tag_valid;
  logic [6:0]  m_adc_tag_type;
  logic        m_adc_last;
  logic        busy;
  logic [31:0] drop_cnt;
  state_t      dbg_state;

  adc_burst_scheduler dut (
    .user_clk        (user_clk),
    .user_rst        (user_rst),
    .pps             (pps),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_num         (cmd_num),
    .cmd_at_pps      (cmd_at_pps),
    .cmd_pkt_len     (cmd_pkt_len),
    .cmd_stop        (cmd_stop),
    .s_adc_valid     (s_adc_valid),
    .s_adc_ready     (s_adc_ready),
    .s_adc_data      (s_adc_data),
    .m_adc_valid     (m_adc_valid),
    .m_adc_ready     (m_adc_ready),
    .m_adc_data      (m_adc_data),
    .m_adc_tag_valid (m_adc_tag_valid),
    .m_adc_tag_type  (m_adc_tag_type),
    .m_adc_last      (m_adc_last),
    .busy            (busy),
    .drop_cnt        (drop_cnt),
    .dbg_state       (dbg_state)
  );

  // Clock / reset
  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: burst phase, beat index within burst, expected output beats
  typedef enum {P_IDLE, P_WAIT, P_RUN} phase_t;
  phase_t      phase = P_IDLE;
  longint      k = 0;
  logic [31:0] m_num = '0;
  logic [15:0] m_pkt = '0;
  bit          stop_pend = 0;
  logic [31:0] m_drop = '0;
  bit          prev_pps = 0;
  logic [72:0] exp_q[$];
  int          beats_out = 0;
  int          rst_edges = 0;
  bit          src_fire = 0;
  bit          cmd_fire = 0;

  // Stimulus controls
  bit src_auto = 0;
  int src_rate = 100;
  int snk_mode = 0;

  always @(negedge user_clk) begin
    if (user_rst) begin
      if (rst_edges > 0) begin
        chk("rst_m_valid", m_adc_valid, 1'b0);
        chk("rst_m_last", m_adc_last, 1'b0);
        chk("rst_tag_valid", m_adc_tag_valid, 1'b0);
        chk("rst_tag_type", m_adc_tag_type, 7'h0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", drop_cnt, 32'h0);
      end
      rst_edges++;
      exp_q.delete();
      phase = P_IDLE; k = 0; stop_pend = 0; m_drop = '0; prev_pps = 0;
      src_fire = 0;
    end else begin
      bit mc_ready;
      rst_edges = 0;
      mc_ready = (phase == P_IDLE) && (exp_q.size() == 0);
      chk("m_valid", m_adc_valid, exp_q.size() != 0);
      chk("cmd_ready", cmd_ready, mc_ready);
      chk("busy", busy, (phase != P_IDLE) || (exp_q.size() != 0));
      chk("s_ready", s_adc_ready, (phase != P_RUN) || (exp_q.size() == 0) || m_adc_ready);
      chk("drop_cnt", drop_cnt, m_drop);
      if (m_adc_valid && exp_q.size() != 0) begin
        chk("m_beat", {m_adc_tag_type, m_adc_tag_valid, m_adc_last, m_adc_data}, exp_q[0]);
        if (m_adc_ready) begin
          void'(exp_q.pop_front());
          beats_out++;
        end
      end
      src_fire = s_adc_valid && s_adc_ready;
      if (src_fire) begin
        if (phase == P_RUN) begin
          bit first, fin, last, tv;
          logic [6:0] tt;
          first = (k == 0);
          fin   = ((m_num != 0) && (k == longint'(m_num) - 1)) || stop_pend;
          last  = fin || ((m_pkt != 0) && ((k % m_pkt) == m_pkt - 1));
          tv    = first || fin;
          tt    = !tv ? 7'h00 : (first && fin) ? 7'h03 : first ? 7'h01 : 7'h02;
          exp_q.push_back({tt, tv, last, s_adc_data});
          k++;
          if (fin) begin
            phase = P_IDLE;
            stop_pend = 0;
          end
        end else if (m_drop != 32'hFFFF_FFFF) begin
          m_drop++;
        end
      end
      if (cmd_valid && mc_ready) begin
        cmd_fire = 1;
        m_num = cmd_num; m_pkt = cmd_pkt_len; k = 0; stop_pend = 0;
        phase = cmd_at_pps ? P_WAIT : P_RUN;
      end else if (phase == P_WAIT) begin
        if (cmd_stop) phase = P_IDLE;
        else if (pps && !prev_pps) phase = P_RUN;
      end else if (phase == P_RUN && cmd_stop) begin
        stop_pend = 1;
      end
      prev_pps = pps;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge user_clk);
    #1;
    if (src_auto && (src_fire || !s_adc_valid)) begin
      s_adc_valid = ($urandom_range(1, 100) <= src_rate);
      s_adc_data  = {$urandom, $urandom};
    end
    case (snk_mode)
      0:       m_adc_ready = 1'b1;
      1:       m_adc_ready = 1'($urandom_range(0, 1));
      default: m_adc_ready = !m_adc_ready;
    endcase
  endtask

  task automatic issue(input logic [31:0] num, input logic [15:0] pl, input logic at);
    int n = 0;
    cmd_num = num; cmd_pkt_len = pl; cmd_at_pps = at;
    cmd_fire = 0; beats_out = 0; cmd_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!cmd_fire && n < 100);
    cmd_valid = 1'b0;
    chk("cmd_accept", cmd_fire, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(phase == P_IDLE && exp_q.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, n < budget, 1'b1);
  endtask

  task automatic pulse_stop();
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
  endtask

  initial begin
    user_rst = 1'b1; pps = 1'b0; cmd_valid = 1'b0; cmd_num = '0; cmd_at_pps = 1'b0;
    cmd_pkt_len = '0; cmd_stop = 1'b0; s_adc_valid = 1'b0; s_adc_data = '0; m_adc_ready = 1'b1;
    repeat (3) tick();
    user_rst = 1'b0;
    tick();

    // Stop while idle has no effect.
    pulse_stop();
    tick();
    chk("idle_stop_busy", busy, 1'b0);

    // Four-beat burst, no packetisation, sink always ready.
    src_auto = 1; src_rate = 100; snk_mode = 0;
    issue(32'd4, 16'd0, 1'b0);
    wait_idle("b4_done", 200);
    chk("b4_beats", beats_out, 4);
    chk("b4_busy", busy, 1'b0);

    // Six beats, packets of two; a command offered mid-burst is ignored.
    issue(32'd6, 16'd2, 1'b0);
    tick();
    cmd_num = 32'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_idle("b6_done", 200);
    chk("b6_beats", beats_out, 6);

    // PPS-aligned start: ten samples dropped while waiting.
    user_rst = 1'b1;
    tick();
    user_rst = 1'b0;
    src_auto = 0; s_adc_valid = 1'b0;
    tick();
    issue(32'd5, 16'd0, 1'b1);
    repeat (2) tick();
    s_adc_valid = 1'b1;
    repeat (10) tick();
    s_adc_valid = 1'b0;
    tick();
    chk("pps_drop10", drop_cnt, 32'd10);
    chk("pps_still_wait", busy, 1'b1);
    pps = 1'b1;
    tick();
    src_auto = 1;
    wait_idle("pps_done", 200);
    chk("pps_beats", beats_out, 5);
    pps = 1'b0;
    tick();

    // PPS already high at acceptance is not an edge; stop returns to idle with no beat.
    pps = 1'b1;
    issue(32'd3, 16'd0, 1'b1);
    repeat (5) tick();
    chk("pps_high_wait", busy, 1'b1);
    pulse_stop();
    tick();
    chk("wait_stop_idle", busy, 1'b0);
    chk("wait_stop_beats", beats_out, 0);
    pps = 1'b0;
    tick();

    // Continuous burst stopped after three beats, sink toggling 1010.
    snk_mode = 2; m_adc_ready = 1'b0;
    issue(32'd0, 16'd0, 1'b0);
    for (int n = 0; n < 200 && k < 3; n++) tick();
    pulse_stop();
    wait_idle("cont_stop_done", 200);
    chk("cont_stop_beats_ge4", beats_out >= 4, 1'b1);

    // Single-sample burst.
    snk_mode = 0;
    issue(32'd1, 16'd0, 1'b0);
    wait_idle("single_done", 100);
    chk("single_beats", beats_out, 1);

    // Randomised bursts.
    for (int it = 0; it < 10; it++) begin
      int num, pl, stop_at;
      bit at;
      num = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 12);
      pl  = $urandom_range(0, 4);
      at  = 1'($urandom_range(0, 1));
      snk_mode = $urandom_range(0, 2);
      src_rate = $urandom_range(30, 100);
      stop_at  = (num == 0 || $urandom_range(0, 2) == 0) ? $urandom_range(0, 8) : -1;
      issue(32'(num), 16'(pl), at);
      if (at) begin
        repeat ($urandom_range(1, 5)) tick();
        pps = 1'b1;
        tick();
        pps = 1'b0;
      end
      if (stop_at >= 0) begin
        repeat (stop_at) tick();
        pulse_stop();
      end
      wait_idle("rand_done", 2000);
    end

    // Reset in the middle of a long burst.
    snk_mode = 0; src_rate = 100;
    issue(32'd100, 16'd0, 1'b0);
    repeat (20) tick();
    user_rst = 1'b1;
    tick();
    chk("mid_rst_m_valid", m_adc_valid, 1'b0);
    chk("mid_rst_drop", drop_cnt, 32'd0);
    src_auto = 0; s_adc_valid = 1'b0;
    user_rst = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    repeat (3) tick();
    chk("post_rst_drop", drop_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_burst_scheduler.md
ADC_BURST_SCHEDULER -- requirements
Module: adc_burst_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 32, burst sample-count width.
REQ-002 SHALL have parameter PKT_W, default 16, packet-length width.
REQ-003 SHALL have parameter TAG_START, default 7'h01, tag on first burst sample; TAG_END, default 7'h02; TAG_SINGLE, default 7'h03.
REQ-004 SHALL use one clock and a synchronous, active-high reset: user_clk and user_rst.
REQ-005 Ports SHALL be:
 user_clk  in  1  sole clock
 user_rst  in  1  sync active-high reset
 pps  in  1  pulse-per-second level, already synchronous to user_clk
 cmd_valid  in  1  burst command offered
 cmd_ready  out  1  command accepted when high with cmd_valid
 cmd_num  in  CNT_W  samples in burst; 0 = continuous
 cmd_at_pps  in  1  1 = start on next pps rising edge; 0 = start next cycle
 cmd_pkt_len  in  PKT_W  samples per packet; 0 = last only at burst end
 cmd_stop  in  1  one-cycle abort/stop request
 s_adc_valid / s_adc_ready / s_adc_data  in / out / in  1 / 1 / 64  source stream
 m_adc_valid / m_adc_ready / m_adc_data  out / in / out  1 / 1 / 64  sink stream
 m_adc_tag_valid  out  1  tag qualifies current m_adc beat
 m_adc_tag_type  out  7  tag code
 m_adc_last  out  1  packet/burst boundary
 busy  out  1  state != IDLE or output register full
 drop_cnt  out  32  samples discarded while not RUN, saturating

Function
REQ-010 States SHALL be IDLE, WAIT_PPS, RUN.
REQ-011 cmd_ready SHALL be 1 only in IDLE with output register empty; command fields latched on cmd_valid&&cmd_ready.
REQ-012 IDLE->WAIT_PPS on accepted command with cmd_at_pps=1; IDLE->RUN with cmd_at_pps=0, first eligible sample on following cycle.
REQ-013 WAIT_PPS->RUN on pps rising edge (pps=1, previous-cycle pps=0); pps already high at acceptance does not count.
REQ-014 WAIT_PPS->IDLE on cmd_stop, no beat emitted.
REQ-015 Outside RUN, s_adc_ready SHALL be 1 and each s_adc_valid beat discarded, drop_cnt +1, saturating at 32'hFFFFFFFF.
REQ-016 In RUN, s_adc_ready = !m_adc_valid || m_adc_ready; accepted beat loaded into one registered output stage (latency 1 cycle, data unchanged).
REQ-017 m_adc_valid and all m_adc_* SHALL hold stable while m_adc_valid && !m_adc_ready.
REQ-018 Burst sample counter SHALL start at 0, increment per accepted beat; in continuous mode it wraps modulo 2^CNT_W without ending burst.
REQ-019 Packet counter SHALL increment per accepted beat, m_adc_last=1 on beat where count = cmd_pkt_len-1, then reset to 0.
REQ-020 Final burst beat (counter = cmd_num-1) SHALL have m_adc_last=1, tag TAG_END; RUN->IDLE at its acceptance into output stage.
REQ-021 First burst beat SHALL have tag TAG_START; if also final (cmd_num=1) tag TAG_SINGLE.
REQ-022 m_adc_tag_valid SHALL be 0 on all other beats; m_adc_tag_type 0 when tag_valid 0.
REQ-023 cmd_stop in RUN SHALL set stop_pending; next accepted beat is final (last=1, TAG_END, or TAG_SINGLE if first); stop_pending cleared on entering IDLE.
REQ-024 cmd_stop coincident with final beat acceptance SHALL be ignored (single end).
REQ-025 cmd_stop in IDLE SHALL have no effect; cmd_valid during non-IDLE ignored.
REQ-026 Output register drains after RUN->IDLE; busy=1 until m_adc_valid falls.

Reset
REQ-030 On user_rst: state IDLE, m_adc_valid 0, m_adc_last 0, m_adc_tag_valid 0, m_adc_tag_type 0, m_adc_data 0, cmd_ready 0 during reset then 1, busy 0, drop_cnt 0, counters 0, pps history 0.
REQ-031 Reset mid-burst SHALL discard in-flight output beat without emitting last.

Structure
REQ-040 Package adc_burst_sched_pkg SHALL hold state encoding and tag constants defaults.
REQ-041 Output register SHALL be sub-module adc_burst_out_reg (64-bit data plus last/tag sideband, valid/ready).

Verification
REQ-050 cmd_num=4, pkt_len=0, at_pps=0, m_adc_ready=1 -> 4 beats, tags 01,-,-,02, last only on beat 4, busy low afterwards.
REQ-051 cmd_num=6, pkt_len=2 -> last on beats 2,4,6; TAG_END only beat 6.
REQ-052 at_pps=1, 10 samples before pps edge -> drop_cnt=10, first emitted sample is first accepted after edge with TAG_START.
REQ-053 continuous, cmd_stop after 3 beats, m_adc_ready toggling 1010 -> beat 4 last with TAG_END, data order intact, no beat lost or duplicated.
REQ-054 cmd_num=1 -> single beat TAG_SINGLE, last=1; user_rst mid 100-sample burst -> m_adc_valid 0 next cycle, drop_cnt 0, cmd_ready 1.
